// File: rtl/pc_lut_encoder_if.sv
// Bus bundle for pc_lut_encoder: table write/clear, forward lookup and
// reverse-search handshake.
//   slave  : the encoder (drives rd_target, busy, done, hit, index)
//   master : the client (drives writes, clr, rd_addr, start, target)
interface pc_lut_encoder_if #(
  parameter int unsigned D = 12
);
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [D-1:0] wr_data;
  logic         clr;
  logic [4:0]   rd_addr;
  logic [D-1:0] rd_target;
  logic         start;
  logic [D-1:0] target;
  logic         busy;
  logic         done;
  logic         hit;
  logic [4:0]   index;

  modport slave (
    input  wr_en, wr_addr, wr_data, clr, rd_addr, start, target,
    output rd_target, busy, done, hit, index
  );

  modport master (
    output wr_en, wr_addr, wr_data, clr, rd_addr, start, target,
    input  rd_target, busy, done, hit, index
  );
endinterface

// File: rtl/pc_lut_encoder.sv
// Branch-target lookup table with a forward read port and a sequential
// reverse search (target value -> lowest matching entry index).
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : pc_lut_encoder_if.slave
//           wr_en/wr_addr/wr_data : store a target and mark the entry valid
//           clr                   : invalidate every entry (data kept)
//           rd_addr -> rd_target  : combinational lookup, 0 if entry invalid
//           start/target          : request a reverse search
//           busy/done/hit/index   : search status and result
module pc_lut_encoder #(
  parameter int unsigned D = 12,
  parameter int unsigned N = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  pc_lut_encoder_if.slave   bus
);

  localparam int unsigned IW = 5;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    mem_q   [N];
  logic [D-1:0]    mem_d   [N];
  logic [N-1:0]    valid_q, valid_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [D-1:0]    tgt_q, tgt_d;
  logic            hit_q, hit_d;
  logic [IW-1:0]   index_q, index_d;

  logic            start_acc_c;
  logic            match_c;
  logic            busy_c;
  logic            done_c;

  // start is only honoured outside SEARCH (IDLE or DONE)
  assign start_acc_c = bus.start && (state_q != S_SEARCH);

  // Compare against pre-edge table contents; same-edge writes land afterwards
  assign match_c = (state_q == S_SEARCH) && valid_q[cnt_q] &&
                   (mem_q[cnt_q] == tgt_q);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc_c) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (match_c || (cnt_q == LAST_IDX)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start_acc_c ? S_SEARCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      S_SEARCH: busy_c = 1'b1;
      S_DONE:   done_c = 1'b1;
      default: ;
    endcase
  end

  // Table update: clr first so a same-edge write survives as the only valid entry
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (bus.clr) valid_d = '0;
    if (bus.wr_en) begin
      mem_d[bus.wr_addr]   = bus.wr_data;
      valid_d[bus.wr_addr] = 1'b1;
    end
  end

  // Search datapath: capture on accepted start, scan without wrapping
  always_comb begin
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    hit_d   = hit_q;
    index_d = index_q;
    if (start_acc_c) begin
      cnt_d   = '0;
      tgt_d   = bus.target;
      hit_d   = 1'b0;
      index_d = '0;
    end else if (state_q == S_SEARCH) begin
      if (match_c) begin
        hit_d   = 1'b1;
        index_d = cnt_q;
      end else if (cnt_q != LAST_IDX) begin
        cnt_d = cnt_q + IW'(1);
      end
    end
  end

  // Datapath and table registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
      index_q <= index_d;
    end
  end

  assign bus.rd_target = valid_q[bus.rd_addr] ? mem_q[bus.rd_addr] : '0;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.hit       = hit_q;
  assign bus.index     = index_q;

endmodule

// File: tb/tb_pc_lut_encoder.sv
// Directed bench for pc_lut_encoder with a reference table model and an
// expected-result queue consumed when done is observed.
module tb_pc_lut_encoder;

  localparam int unsigned D = 12;

  typedef struct {
    logic       hit;
    logic [4:0] idx;
    int         lat;
  } exp_t;

  logic Clk;
  logic Reset;

  pc_lut_encoder_if #(.D(D)) bus ();

  pc_lut_encoder #(.D(D), .N(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [D-1:0] model_mem   [32];
  logic         model_valid [32];
  exp_t         exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model_mem[i]   = '0;
      model_valid[i] = 1'b0;
    end
  endtask

  function automatic exp_t model_search(input logic [D-1:0] t);
    exp_t e;
    e.hit = 1'b0;
    e.idx = '0;
    e.lat = 32;
    for (int i = 31; i >= 0; i--) begin
      if (model_valid[i] && model_mem[i] == t) begin
        e.hit = 1'b1;
        e.idx = 5'(i);
        e.lat = i + 1;
      end
    end
    return e;
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [D-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    model_mem[a]   = d;
    model_valid[a] = 1'b1;
  endtask

  task automatic check_rd(input string tag, input logic [4:0] a, input logic [D-1:0] expv);
    bus.rd_addr = a;
    #1;
    check(tag, 32'(bus.rd_target), 32'(expv));
  endtask

  // Drive start for one edge; the accepting edge must clear hit/index and raise busy
  task automatic begin_search(input logic [D-1:0] t);
    bus.start  = 1'b1;
    bus.target = t;
    exp_q.push_back(model_search(t));
    step();
    bus.start = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_done", 32'(bus.done), 32'd0);
    check("accept_hit_clr", 32'(bus.hit), 32'd0);
    check("accept_idx_clr", 32'(bus.index), 32'd0);
  endtask

  // Wait for done (bounded) counting edges since the accepting edge
  task automatic finish_search(input int already);
    int   n;
    bit   got;
    exp_t e;
    n   = already;
    got = 1'b0;
    while (n < 40 && !got) begin
      step();
      n++;
      if (bus.done === 1'b1) got = 1'b1;
      else check("busy_in_search", 32'(bus.busy), 32'd1);
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("hit", 32'(bus.hit), 32'(e.hit));
      check("index", 32'(bus.index), 32'(e.idx));
      check("latency", 32'(n), 32'(e.lat));
      check("busy_in_done", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.clr     = 1'b0;
    bus.rd_addr = '0;
    bus.start   = 1'b0;
    bus.target  = '0;
    model_reset();
    Reset = 1'b0;
    step();
    step();

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_index", 32'(bus.index), 32'd0);
    check_rd("rst_rd0", 5'd0, '0);
    Reset = 1'b1;
    step();

    // Load table 0..7
    do_write(5'd0, 12'd13);
    do_write(5'd1, 12'd20);
    do_write(5'd2, 12'd2);
    do_write(5'd3, 12'd7);
    do_write(5'd4, 12'd7);
    do_write(5'd5, 12'd117);
    do_write(5'd6, 12'd59);
    do_write(5'd7, 12'd132);
    check_rd("rd5", 5'd5, 12'd117);
    check_rd("rd7", 5'd7, 12'd132);
    check_rd("rd8_invalid", 5'd8, '0);

    // Hit at index 5, then result must hold while IDLE
    begin_search(12'd117);
    finish_search(0);
    step();
    check("post_done_low", 32'(bus.done), 32'd0);
    check("post_busy_low", 32'(bus.busy), 32'd0);
    check("hold_hit", 32'(bus.hit), 32'd1);
    check("hold_index", 32'(bus.index), 32'd5);

    // Duplicate value: lowest index wins
    begin_search(12'd7);
    finish_search(0);
    step();

    // Full miss
    begin_search(12'd999);
    finish_search(0);
    check_rd("miss_rd8", 5'd8, '0);
    step();

    // Back-to-back: start in DONE cycle, extra start during SEARCH ignored
    begin_search(12'd2);
    finish_search(0);
    begin_search(12'd20);
    bus.start  = 1'b1;
    bus.target = 12'd13;
    step();
    bus.start = 1'b0;
    finish_search(1);
    step();

    // Write to an already-scanned entry during search does not change result
    begin_search(12'd117);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 12'd117;
    step();
    bus.wr_en = 1'b0;
    finish_search(1);
    model_mem[0]   = 12'd117;
    model_valid[0] = 1'b1;
    check_rd("late_write_rd0", 5'd0, 12'd117);
    step();

    // clr together with a write: only the written entry survives
    do_write(5'd0, 12'd13);
    bus.clr     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 12'd55;
    step();
    bus.clr   = 1'b0;
    bus.wr_en = 1'b0;
    for (int i = 0; i < 32; i++) model_valid[i] = 1'b0;
    model_mem[9]   = 12'd55;
    model_valid[9] = 1'b1;
    check_rd("clrwr_rd9", 5'd9, 12'd55);
    check_rd("clrwr_rd5", 5'd5, '0);
    begin_search(12'd13);
    finish_search(0);
    check_rd("clr_rd0", 5'd0, '0);
    step();

    // Reset in the middle of a search aborts with no done pulse
    do_write(5'd7, 12'd132);
    begin_search(12'd132);
    step();
    step();
    #2;
    Reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_hit", 32'(bus.hit), 32'd0);
    check("rst_mid_index", 32'(bus.index), 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("rst_no_done", 32'(bus.done), 32'd0);
    end
    check_rd("rst_rd7", 5'd7, '0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_reset();
    Reset = 1'b1;

    // First start after reset is accepted on the next edge; table is empty
    begin_search(12'd132);
    finish_search(0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
